// File: rtl/adder_slice_sequencer.sv
// Wide unsigned adder that reuses one narrow adder_nbit slice per clock,
// least-significant slice first, with the carry held in a register between slices.

module adder_nbit #(
  parameter int BIT_WIDTH = 4
) (
  input  logic [BIT_WIDTH-1:0] i_a,
  input  logic [BIT_WIDTH-1:0] i_b,
  input  logic                 i_cin,
  output logic [BIT_WIDTH-1:0] o_sum,
  output logic                 o_cout
);
  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{BIT_WIDTH{1'b0}}, i_cin};
endmodule

// state   | meaning
// ST_IDLE | waiting for start; sum/overflow hold the last result
// ST_ADD  | one slice added per edge, slice index r_idx
// ST_DONE | one-cycle done pulse; start here begins the next operation
module adder_slice_sequencer #(
  parameter int BIT_WIDTH  = 4,
  parameter int NUM_SLICES = 4
) (
  input  logic                             clk,
  input  logic                             n_rst,
  input  logic                             start,
  input  logic [BIT_WIDTH*NUM_SLICES-1:0]  a,
  input  logic [BIT_WIDTH*NUM_SLICES-1:0]  b,
  input  logic                             carry_in,
  output logic                             busy,
  output logic                             done,
  output logic [BIT_WIDTH*NUM_SLICES-1:0]  sum,
  output logic                             overflow
);
  localparam int TOTAL = BIT_WIDTH * NUM_SLICES;
  localparam int IDX_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_accept;
  logic                 w_busy;
  logic                 w_done;
  logic                 w_last;

  logic [TOTAL-1:0]     r_a;
  logic [TOTAL-1:0]     r_b;
  logic                 r_carry;
  logic [IDX_W-1:0]     r_idx;
  logic [TOTAL-1:0]     r_part;
  logic [TOTAL-1:0]     r_sum;
  logic                 r_ovf;

  logic [31:0]          w_off;
  logic [BIT_WIDTH-1:0] w_a_sl;
  logic [BIT_WIDTH-1:0] w_b_sl;
  logic [BIT_WIDTH-1:0] w_slice_sum;
  logic                 w_cout;
  logic [TOTAL-1:0]     w_slice_mask;
  logic [TOTAL-1:0]     w_part_nxt;

  assign w_last = (r_idx == LAST_IDX);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_ADD;
        end
      end
      ST_ADD: begin
        w_busy = 1'b1;
        if (w_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_done = 1'b1;
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_ADD;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Slice selection by shifting keeps the index inside the operand for any idx value.
  assign w_off        = 32'(r_idx) * 32'(BIT_WIDTH);
  assign w_a_sl       = BIT_WIDTH'(r_a >> w_off);
  assign w_b_sl       = BIT_WIDTH'(r_b >> w_off);
  assign w_slice_mask = TOTAL'({BIT_WIDTH{1'b1}}) << w_off;
  assign w_part_nxt   = (r_part & ~w_slice_mask) | (TOTAL'(w_slice_sum) << w_off);

  adder_nbit #(.BIT_WIDTH(BIT_WIDTH)) u_slice (
    .i_a    (w_a_sl),
    .i_b    (w_b_sl),
    .i_cin  (r_carry),
    .o_sum  (w_slice_sum),
    .o_cout (w_cout)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_part  <= '0;
      r_sum   <= '0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_carry <= carry_in;
      r_idx   <= '0;
    end else if (r_state == ST_ADD) begin
      r_part  <= w_part_nxt;
      r_carry <= w_cout;
      if (w_last) begin
        r_sum <= w_part_nxt;
        r_ovf <= w_cout;
        r_idx <= '0;
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign busy     = w_busy;
  assign done     = w_done;
  assign sum      = r_sum;
  assign overflow = r_ovf;
endmodule

// File: doc/adder_slice_sequencer.md
Name: adder_slice_sequencer

Overview:
- Sequential controller that computes a wide unsigned add (BIT_WIDTH*NUM_SLICES bits) by time-multiplexing one narrow adder_nbit instance (width BIT_WIDTH), one slice per clock, least-significant slice first.
- Carry is held in a register between slices.
- Sits between a requesting unit (start/done handshake) and the shared adder datapath.
- Trades area for latency: NUM_SLICES cycles per operation.

Parameters:
- BIT_WIDTH, 4, width of the internal adder_nbit slice.
- NUM_SLICES, 4, number of slices per operation (>=1). TOTAL = BIT_WIDTH*NUM_SLICES.

Ports:
- clk  input  1  system clock, rising-edge.
- n_rst  input  1  asynchronous active-low reset.
- start  input  1  request, sampled on rising clk edge.
- a  input  TOTAL  operand A, sampled with accepted start.
- b  input  TOTAL  operand B, sampled with accepted start.
- carry_in  input  1  initial carry, sampled with accepted start.
- busy  output  1  high while slices are being added.
- done  output  1  one-cycle pulse: sum/overflow valid and updated.
- sum  output  TOTAL  registered result of last completed operation.
- overflow  output  1  carry out of the top slice of last completed operation.

Behaviour:
- Interface: one clock (clk); reset n_rst is asynchronous, active-low.
- Reset (n_rst=0, any time, including mid-operation):
  - state=IDLE, busy=0, done=0, sum=0, overflow=0.
  - Slice index, carry register and operand registers cleared.
  - An operation in progress is aborted and never produces done.
- States: IDLE, ADD, DONE.
- IDLE:
  - start=1 at edge -> latch a, b, carry_in into operand/carry registers.
  - idx=0 -> ADD.
  - start=0 -> stay.
- ADD:
  - Combinational adder_nbit inputs = operand slices [idx*BIT_WIDTH +: BIT_WIDTH] and carry register.
  - Each edge: write slice result into the partial-sum register at slice idx; carry register <= slice carry out; idx++.
  - On the edge writing slice NUM_SLICES-1:
    - sum <= complete partial sum.
    - overflow <= final carry.
    - -> DONE.
- DONE:
  - done=1 for exactly this one cycle.
  - Next edge: start=1 accepts a new operation exactly as from IDLE (-> ADD, back-to-back allowed); otherwise -> IDLE.
- busy=1 only in ADD. done=1 only in DONE. Both are Moore outputs.
- Latency: start sampled at edge E0 -> busy from E0 to E_NUM_SLICES -> done high in cycle after edge E_NUM_SLICES.
  - NUM_SLICES=4: done visible 4 edges after start was sampled.
- Throughput: one operation per NUM_SLICES+1 cycles.
- start while in ADD is ignored; the operand registers are not reloaded.
- a, b and carry_in may change freely after acceptance without affecting the result.
- sum and overflow change only on the completing edge. They hold their value through IDLE until the next completion.
- Arithmetic: unsigned; {overflow,sum} = a + b + carry_in, modulo 2^(TOTAL+1).
- Carry propagates across slice boundaries through the carry register only, never combinationally between cycles.
- NUM_SLICES=1: ADD lasts one cycle; the block degenerates to a registered adder with a done pulse.
- idx width is clog2(NUM_SLICES), minimum 1 bit. idx must never address beyond slice NUM_SLICES-1.

Test Plan (BIT_WIDTH=4, NUM_SLICES=4):
- Reset, then a=0x1234, b=0x4321, cin=0, start pulse:
  - Required: busy=1 for 4 cycles, then done=1 for 1 cycle, sum=0x5555, overflow=0.
- a=0x000F, b=0x0001, cin=0:
  - Required: sum=0x0010, overflow=0 (carry crosses a slice boundary).
- a=0xFFFF, b=0x0000, cin=1:
  - Required: sum=0x0000, overflow=1 (carry ripples through all 4 slices).
- start held high with new operands (0x1111+0x1111) during ADD of 0x0001+0x0001:
  - Required: first done gives sum=0x0002.
  - The request is accepted in DONE: a second op completes 5 cycles later with sum=0x2222.
- n_rst asserted after 2 ADD cycles of 0xFFFF+0x0001:
  - Required: immediately busy=0, sum=0x0000, overflow=0.
  - No done pulse; the next operation 0x0003+0x0004 gives 0x0007.
- Operands changed to 0xAAAA/0x5555 the cycle after start accepted 0x0100+0x0200:
  - Required: sum=0x0300, overflow=0.
